sdram_host_arbiter: RTL
=======================

# sdram_host_arbiter

Round-robin arbiter that shares the single host port of `sdram_controller` among `NREQ` independent requesters in the `clk` (143 MHz SDRAM) domain. It holds each granted command stable until the controller accepts it and records the requester ID of every read in an in-order tag FIFO. It then steers each returned read word back to the requester that issued it. It sits between the per-client command sources (e.g. clock-domain-crossing FIFOs) and `sdram_controller`.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `AWIDTH`, 24, host address width (bank+row+column)
- `DWIDTH`, 16, data width
- `TAG_DEPTH`, 4, max outstanding reads; power of two
- `clk`  in  1  SDRAM clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester command valid
- `req_ready`  out  NREQ  one-hot grant; command taken this cycle
- `req_we`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*AWIDTH  packed addresses; requester i at [i*AWIDTH +: AWIDTH]
- `req_wdata`  in  NREQ*DWIDTH  packed write data, same packing
- `rd_valid`  out  NREQ  one-hot, 1-cycle read-return strobe
- `rd_data`  out  DWIDTH  read word, shared by all requesters
- `ctrl_busy`  in  1  controller `busy`
- `ctrl_haddr`  out  AWIDTH  to controller `haddr`
- `ctrl_hrw`  out  1  to controller `hrw` (1 = write)
- `ctrl_hrw_req`  out  1  to controller `hrw_req`
- `ctrl_hdata_in`  out  DWIDTH  to controller `hdata_in`
- `ctrl_hdata_out`  in  DWIDTH  from controller `hdata_out`
- `ctrl_hdata_out_valid`  in  1  from controller `hdata_out_valid`
- `orphan_err`  out  1  sticky: read data returned with no outstanding tag

## Operation
- FSM states: IDLE and ISSUE.
- IDLE:
  - Requester i is eligible when `req_valid[i]` is high and either `req_we[i]`=1 or the tag FIFO is not full.
  - Winner = first eligible requester scanning from `rr_ptr` upward, modulo NREQ.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - At the clock edge: the command is latched into the `ctrl_*` registers, `rr_ptr` ← winner+1 mod NREQ, a read pushes the winner ID into the tag FIFO, and the FSM moves to ISSUE.
  - With no eligible requester, the FSM stays in IDLE.
- ISSUE:
  - `ctrl_hrw_req`=1; `ctrl_haddr`, `ctrl_hrw` and `ctrl_hdata_in` are held stable.
  - The command is accepted on an edge where `ctrl_hrw_req`=1 and `ctrl_busy`=0; the FSM then returns to IDLE.
  - While `ctrl_busy`=1 the FSM waits indefinitely; `req_ready` stays 0.
- Read return:
  - On `ctrl_hdata_out_valid`=1, pop the tag FIFO.
  - Next cycle: `rd_data` ← `ctrl_hdata_out` and `rd_valid[tag]`=1 for one cycle.
  - If the FIFO is empty at that moment: no `rd_valid` strobe, and `orphan_err` ← 1, held until `rst`.
- Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- Full is evaluated on pre-edge occupancy; a same-cycle pop does not make a blocked read eligible.
- Writes are never blocked by a full tag FIFO.
- The controller returns reads in issue order; the arbiter relies on this.

## Timing
- Reset values:
  - `req_ready`=0, `rd_valid`=0, `rd_data`=0
  - `ctrl_hrw_req`=0, `ctrl_haddr`=0, `ctrl_hrw`=0, `ctrl_hdata_in`=0
  - `orphan_err`=0, `rr_ptr`=0, tag FIFO empty, FSM in IDLE
- Grant: `req_ready` rises in the same cycle `req_valid` is seen in IDLE (cycle 0). `ctrl_hrw_req` rises at cycle 1.
- If `ctrl_busy`=0, acceptance occurs at the end of cycle 1 and the FSM is back in IDLE at cycle 2. Peak throughput is one command per 2 cycles.
- Read return: `rd_valid` rises exactly 1 cycle after `ctrl_hdata_out_valid`.
- A requester must hold its command stable from `req_valid` until `req_ready`.
- Reset mid-operation: the pending command and all outstanding tags are dropped. Any in-flight data the controller returns afterwards sets `orphan_err`.

## Structure
- Shared header `sdram_arb_defs.vh` holds:
  - FSM state encodings (`ARB_IDLE`, `ARB_ISSUE`)
  - default widths (AWIDTH 24, DWIDTH 16)
  - tag width `$clog2(NREQ)`
- Sub-module `rd_tag_fifo`: single-clock FIFO, width `$clog2(NREQ)`, depth `TAG_DEPTH`. It has a count register, a full/empty flag, same-cycle push+pop support, and the same async reset.

## Test plan
- Single write: req 2 sends addr 0x000010, wdata 0x00C3, `ctrl_busy`=0 → `req_ready`=4'b0100 at cycle 0; `ctrl_hrw_req`=1, `ctrl_haddr`=0x000010, `ctrl_hrw`=1 at cycle 1 only.
- Round-robin: all 4 requesters hold writes continuously → grant order 0,1,2,3,0,…, one grant every 2 cycles.
- Busy stall: `ctrl_busy`=1 for 10 cycles during ISSUE → `ctrl_hrw_req` and command stay stable for 10 cycles, no new grant; accepted on the first busy-low edge.
- Read routing: req 1 reads A, then req 3 reads B; model returns 0x1111, then 0x3333 → `rd_valid`=4'b0010 with 0x1111, then 4'b1000 with 0x3333.
- Tag full: TAG_DEPTH=4 reads outstanding → reads blocked while a pending write from another requester is granted; one return unblocks the next read.
- Orphan and reset: assert `rst` with 2 reads outstanding, then pulse `ctrl_hdata_out_valid` → no `rd_valid`, `orphan_err`=1 until the next `rst`.

Source files
------------

// File: rtl/sdram_host_arbiter_pkg.sv
// Shared definitions for the SDRAM host-port arbiter.
//   arb_state_e : arbiter FSM states (idle / command presented to controller)
//   DEF_AWIDTH  : default host address width (bank+row+column)
//   DEF_DWIDTH  : default data width
//   tag_width() : bits needed to hold a requester ID
package sdram_host_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_AWIDTH = 24;
  localparam int unsigned DEF_DWIDTH = 16;

  function automatic int unsigned tag_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sdram_host_arbiter_rd_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_push        : write i_push_data (ignored when full unless popping too)
//   i_pop         : release head entry (ignored when empty)
//   o_pop_data    : current head entry
//   o_full/o_empty: occupancy flags, derived from the count register
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == (PW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the sdram_controller host port among NREQ
// requesters. The granted command is registered and held until the
// controller accepts it; read requester IDs go into an in-order tag FIFO so
// each returned word is steered back to its issuer.
//   clk, rst             : SDRAM clock, asynchronous active-high reset
//   req_valid/we/addr/wdata : per-requester commands (packed, i*W +: W)
//   req_ready            : one-hot combinational grant
//   rd_valid, rd_data    : one-hot read-return strobe and shared data
//   ctrl_*               : controller host port
//   orphan_err           : sticky, read data arrived with no tag outstanding
module sdram_host_arbiter
  import sdram_host_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]        rd_valid,
  output logic [DWIDTH-1:0]      rd_data,
  input  logic                   ctrl_busy,
  output logic [AWIDTH-1:0]      ctrl_haddr,
  output logic                   ctrl_hrw,
  output logic                   ctrl_hrw_req,
  output logic [DWIDTH-1:0]      ctrl_hdata_in,
  input  logic [DWIDTH-1:0]      ctrl_hdata_out,
  input  logic                   ctrl_hdata_out_valid,
  output logic                   orphan_err
);

  localparam int unsigned TW = tag_width(NREQ);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [TW-1:0]     r_rr_ptr;
  logic [TW-1:0]     w_winner;
  logic [TW-1:0]     w_rr_nxt;
  logic [TW-1:0]     w_tag;
  logic              w_found;
  logic              w_grant;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [NREQ-1:0]   w_elig;
  logic [AWIDTH-1:0] r_haddr;
  logic              r_hrw;
  logic [DWIDTH-1:0] r_hdata_in;
  logic [NREQ-1:0]   r_rd_valid;
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_orphan;

  // Full is the pre-edge flag, so a same-cycle pop never unblocks a read.
  assign w_elig = req_valid & (req_we | {NREQ{!w_full}});

  // Rotating priority scan starting at r_rr_ptr.
  always_comb begin
    int unsigned v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = 32'(r_rr_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && w_elig[v_idx[TW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_idx[TW-1:0];
      end
    end
  end

  assign w_rr_nxt  = (32'(w_winner) == NREQ - 1) ? '0 : w_winner + TW'(1);
  assign w_grant   = (r_state == ARB_IDLE) && w_found;
  assign w_push    = w_grant && !req_we[w_winner];
  assign req_ready = (w_grant && !rst) ? (NREQ'(1) << w_winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_found)    w_state_nxt = ARB_ISSUE;
      ARB_ISSUE: if (!ctrl_busy) w_state_nxt = ARB_IDLE;
      default:                   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Command registers: loaded only on grant, then held through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_haddr    <= '0;
      r_hrw      <= 1'b0;
      r_hdata_in <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_haddr    <= req_addr[w_winner*AWIDTH +: AWIDTH];
      r_hrw      <= req_we[w_winner];
      r_hdata_in <= req_wdata[w_winner*DWIDTH +: DWIDTH];
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  rd_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_data (w_winner),
    .i_pop       (ctrl_hdata_out_valid),
    .o_pop_data  (w_tag),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_orphan   <= 1'b0;
    end else begin
      r_rd_valid <= '0;
      if (ctrl_hdata_out_valid) begin
        r_rd_data <= ctrl_hdata_out;
        if (w_empty) r_orphan   <= 1'b1;
        else         r_rd_valid <= NREQ'(1) << w_tag;
      end
    end
  end

  assign ctrl_hrw_req  = (r_state == ARB_ISSUE);
  assign ctrl_haddr    = r_haddr;
  assign ctrl_hrw      = r_hrw;
  assign ctrl_hdata_in = r_hdata_in;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign orphan_err    = r_orphan;

endmodule
